alu_op_sequencer: RTL

//  Queues ALU commands {op, a, b} and sequences the operand latch, 4-bit ALU and UART transmitter for each one.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer_cmd_fifo.sv | 56 +++++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        SETTLE,
        SEND,
        WAIT_TX,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } alu_cmd_t;

    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int ALU_LAT_DEF      = 2;
    localparam int BUSY_TIMEOUT_DEF = 16;

    // Wide enough for both the settle hold and the busy timeout window.
    localparam int SEQ_CNT_W = 8;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Pin bundle between command source, sequencer and ALU/UART datapath.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side; uartbusy on the UART side.
// Modports: slave = sequencer view, master = environment (command source + datapath) view.
interface alu_op_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic             alu_save_a_n;
    logic             alu_save_b_n;
    logic [3:0]       alu_data;
    logic [3:0]       alu_op_select;
    logic             uart_tx_en;
    logic             uartbusy;
    logic             done_pulse;
    logic             err_timeout;
    logic             err_clr;
    logic [CNT_W-1:0] fifo_count;
    logic             seq_busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, uartbusy, err_clr,
        output cmd_ready, alu_save_a_n, alu_save_b_n, alu_data, alu_op_select,
               uart_tx_en, done_pulse, err_timeout, fifo_count, seq_busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, uartbusy, err_clr,
        input  cmd_ready, alu_save_a_n, alu_save_b_n, alu_data, alu_op_select,
               uart_tx_en, done_pulse, err_timeout, fifo_count, seq_busy
    );
endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of alu_cmd_t with occupancy count.
// Latency: 1 clk push-to-visible at head; head is valid whenever o_count != 0.
// Backpressure: o_rdy low when full; a push while full is dropped.
// Ports: i_push/i_dat/o_rdy write side, i_pop/o_head read side, o_count occupancy.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  alu_cmd_t               i_dat,
    output logic                   o_rdy,
    input  logic                   i_pop,
    output alu_cmd_t               o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdy   = !w_full;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues {op,a,b} commands and steps latch -> ALU -> UART for each.
// Latency: save_a_n falls 1 clk after the pop; >= 5+ALU_LAT+frame clks per command.
// Backpressure: cmd_ready low when the queue is full; uartbusy holds the FSM in WAIT_TX.
// Ports: clk, reset_n (async, active-low); bus carries command handshake, latch strobes,
//        operand/op select, UART enable/busy, done/error status, queue count and busy flag.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int ALU_LAT      = ALU_LAT_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_op_sequencer_if.slave  bus
);
    seq_state_t                  r_state;
    seq_state_t                  w_next;
    logic [SEQ_CNT_W-1:0]        r_cnt;
    logic [3:0]                  r_b;
    logic [3:0]                  r_op_sel;
    logic [3:0]                  r_alu_data;
    logic                        r_err;

    alu_cmd_t                    w_in;
    alu_cmd_t                    w_head;
    logic                        w_rdy;
    logic                        w_pop;
    logic                        w_timeout;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_save_a_n;
    logic                        w_save_b_n;
    logic                        w_tx_en;
    logic                        w_done;

    assign w_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (bus.cmd_valid),
        .i_dat   (w_in),
        .o_rdy   (w_rdy),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_b        <= '0;
            r_op_sel   <= '0;
            r_alu_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state change, so SETTLE and SEND
            // each measure their own dwell from zero.
            if (w_next != r_state)                  r_cnt <= '0;
            else if (r_state == SETTLE || r_state == SEND) r_cnt <= r_cnt + SEQ_CNT_W'(1);

            // op select is only written at the pop, so it stays put for
            // the whole command including the UART frame.
            if (w_pop) begin
                r_b        <= w_head.b;
                r_op_sel   <= w_head.op;
                r_alu_data <= w_head.a;
            end else if (r_state == LOAD_A) begin
                r_alu_data <= r_b;
            end

            if (bus.err_clr)    r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_timeout  = 1'b0;
        w_save_a_n = 1'b1;
        w_save_b_n = 1'b1;
        w_tx_en    = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count != '0) begin
                    w_pop  = 1'b1;
                    w_next = LOAD_A;
                end
            end
            LOAD_A: begin
                w_save_a_n = 1'b0;
                w_next     = LOAD_B;
            end
            LOAD_B: begin
                w_save_b_n = 1'b0;
                w_next     = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == SEQ_CNT_W'(ALU_LAT - 1)) w_next = SEND;
            end
            SEND: begin
                w_tx_en = 1'b1;
                if (bus.uartbusy) begin
                    w_next = WAIT_TX;
                end else if (r_cnt == SEQ_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            WAIT_TX: begin
                if (!bus.uartbusy) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.cmd_ready     = w_rdy;
    assign bus.alu_save_a_n  = w_save_a_n;
    assign bus.alu_save_b_n  = w_save_b_n;
    assign bus.alu_data      = r_alu_data;
    assign bus.alu_op_select = r_op_sel;
    assign bus.uart_tx_en    = w_tx_en;
    assign bus.done_pulse    = w_done;
    assign bus.err_timeout   = r_err;
    assign bus.fifo_count    = w_count;
    assign bus.seq_busy      = (r_state != IDLE);
endmodule
